// File: rtl/dp_types_pkg.sv
// Shared datapath types for the 5-stage MIPS pipeline: register indices,
// hazard-unit FSM states and the default result latencies.
package dp_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} hu_state_t;

  localparam int LAT_ALU_NOFWD  = 2;
  localparam int LAT_LOAD_NOFWD = 2;
  localparam int LAT_ALU_FWD    = 0;
  localparam int LAT_LOAD_FWD   = 1;

  // Countdown width able to hold 0..max(lat_alu, lat_load), never zero bits.
  function automatic int sb_cnt_width(int lat_alu, int lat_load);
    int lmax;
    lmax = (lat_alu > lat_load) ? lat_alu : lat_load;
    return (lmax < 1) ? 1 : $clog2(lmax + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write countdowns: two read ports, one issue port and a
// global decrement driven by pipeline advance.
module hazard_scoreboard
  import dp_types_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CW    = 2,
  parameter int IW    = $clog2(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          dec_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [CW-1:0] wr_lat_i,
  input  logic [IW-1:0] rd0_idx_i,
  input  logic [IW-1:0] rd1_idx_i,
  output logic [CW-1:0] rd0_o,
  output logic [CW-1:0] rd1_o,
  output logic          all_zero_o
);

  logic [CW-1:0] cnt_q [NREGS];
  logic [CW-1:0] cnt_d [NREGS];
  logic [CW-1:0] dec_v;

  always_comb begin
    dec_v = '0;
    for (int r = 0; r < NREGS; r++) begin
      dec_v = cnt_q[r];
      if (dec_i && (cnt_q[r] != '0)) dec_v = cnt_q[r] - CW'(1);
      cnt_d[r] = dec_v;
      // A new write never shortens an older, longer pending write.
      if (wr_en_i && (wr_idx_i == IW'(r)) && (wr_lat_i > dec_v)) cnt_d[r] = wr_lat_i;
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    all_zero_o = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      if (cnt_q[r] != '0) all_zero_o = 1'b0;
    end
  end

  assign rd0_o = cnt_q[rd0_idx_i];
  assign rd1_o = cnt_q[rd1_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboard-based RAW stalls, mispredict flushes,
// halt-drain FSM and a saturating stall-cycle counter.
module hazard_ctrl
  import dp_types_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int LAT_ALU  = LAT_ALU_NOFWD,
  parameter int LAT_LOAD = LAT_LOAD_NOFWD,
  parameter int SCW      = 32
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           ihit,
  input  logic           dhit,
  input  logic           id_valid,
  input  regbits_t       id_rs,
  input  regbits_t       id_rt,
  input  regbits_t       id_rd,
  input  logic           id_regWEN,
  input  logic           id_is_load,
  input  logic           mispredict,
  input  logic           halt,
  output logic           pcen,
  output logic           if_id_en,
  output logic           id_ex_en,
  output logic           ex_mem_en,
  output logic           mem_wb_en,
  output logic           if_id_flush,
  output logic           id_ex_flush,
  output logic           ex_mem_flush,
  output logic           mem_wb_flush,
  output logic           stall,
  output logic           halted,
  output logic [SCW-1:0] stall_cnt
);

  localparam int CW = sb_cnt_width(LAT_ALU, LAT_LOAD);
  localparam int IW = $clog2(NREGS);

  hu_state_t      state_q;
  logic           halted_q;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

  logic           adv, raw, run, issue, sb_zero;
  logic [CW-1:0]  rs_cnt, rt_cnt, lat_sel;

  assign adv     = ihit | dhit;
  assign run     = (state_q == RUN);
  assign raw     = id_valid & (((id_rs != '0) & (rs_cnt != '0)) |
                               ((id_rt != '0) & (rt_cnt != '0)));
  assign stall   = raw & ~mispredict & run;
  assign issue   = adv & id_valid & id_regWEN & (id_rd != '0) & ~stall & ~mispredict & run;
  assign lat_sel = id_is_load ? CW'(LAT_LOAD) : CW'(LAT_ALU);

  hazard_scoreboard #(
    .NREGS (NREGS),
    .CW    (CW),
    .IW    (IW)
  ) u_sb (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .dec_i      (adv),
    .wr_en_i    (issue),
    .wr_idx_i   (id_rd[IW-1:0]),
    .wr_lat_i   (lat_sel),
    .rd0_idx_i  (id_rs[IW-1:0]),
    .rd1_idx_i  (id_rt[IW-1:0]),
    .rd0_o      (rs_cnt),
    .rd1_o      (rt_cnt),
    .all_zero_o (sb_zero)
  );

  // Mispredict outranks a RAW stall: the dependent instruction is flushed anyway.
  always_comb begin
    pcen         = ihit;
    if_id_en     = adv;
    id_ex_en     = adv;
    ex_mem_en    = adv;
    mem_wb_en    = adv;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (stall) begin
          if_id_en    = 1'b0;
          pcen        = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      DRAIN: begin
        pcen        = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: begin
        pcen      = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end
    endcase
  end

  // Halt is accepted only after every pending write has retired.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN:   if (halt) state_q <= DRAIN;
        DRAIN: begin
          if (sb_zero && adv) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + SCW'(1) : stall_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS datapath. It replaces the fixed EX/MEM register comparison with a per-register scoreboard of pending-write countdowns, so stall distance is set by latency parameters: full stall with no forwarding, or load-use only with forwarding. It also sequences branch-mispredict flushes and runs a halt-drain state machine. A saturating stall counter is provided for performance measurement.

## Interface
- NREGS, 32, architectural register count; indices are regbits_t.
- LAT_ALU, 2, cycles after issue before an ALU result is readable in ID. Use 2 without forwarding, 0 with forwarding.
- LAT_LOAD, 2, the same for loads. Use 2 without forwarding, 1 with forwarding.
- SCW, 32, stall counter width.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit, dhit  in  1 each  cache hits; adv = ihit | dhit.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  regbits_t each  ID-stage source and destination registers.
- id_regWEN  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load; selects LAT_LOAD.
- mispredict  in  1  branch resolved in MEM disagrees with the prediction.
- halt  in  1  halt instruction reached MEM.
- pcen  out  1  PC enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  latch flushes.
- stall  out  1  RAW stall this cycle.
- halted  out  1  pipeline drained and frozen.
- stall_cnt  out  SCW  saturating count of stall cycles.

## Operation
**Scoreboard**
- One counter cnt[r] per register, r in 0..NREGS-1. Width CW = $clog2(max(LAT_ALU, LAT_LOAD) + 1).
- cnt[0] is hardwired to 0.

**RAW stall**
- raw = id_valid & ((id_rs != 0 & cnt[id_rs] != 0) | (id_rt != 0 & cnt[id_rt] != 0)).
- stall = raw & ~mispredict & state == RUN.

**Issue**
- issue = adv & id_valid & id_regWEN & id_rd != 0 & ~stall & ~mispredict & state == RUN.

**Counter update on each edge**
- If adv, every nonzero cnt decrements by 1.
- If issue, cnt[id_rd] <= max(decremented value, lat), where lat = id_is_load ? LAT_LOAD : LAT_ALU.
- Issue overrides the decrement for that register only.

**Default outputs**
- All four latch enables = adv.
- pcen = ihit.
- All flushes = 0.

**Stall**
- if_id_en = 0, pcen = 0, id_ex_flush = 1 (bubble).
- EX, MEM and WB continue.

**Mispredict** (takes priority over stall)
- if_id_flush = id_ex_flush = ex_mem_flush = 1; pcen = ihit.
- The scoreboard is not modified. Entries left by flushed instructions drain naturally; the only cost is conservative extra stall cycles, never incorrect results.

**FSM** (states held in hu_state_t)
- RUN: outputs as above. halt moves to DRAIN. Mispredict in the same cycle as halt is still honoured.
- DRAIN: pcen = 0, if_id_en = 0, id_ex_flush = 1, other enables = adv. When every cnt == 0 and adv is high, move to HALTED.
- HALTED: all enables = 0, pcen = 0, halted = 1. Only reset leaves this state.

**Stall counter**
- stall_cnt increments on each cycle with stall = 1.
- It saturates at all-ones.

## Timing
- Reset (async, nRST = 0): state = RUN, all cnt = 0, stall_cnt = 0, halted = 0. Combinational outputs follow their inputs immediately.
- Reset mid-DRAIN or mid-HALTED returns to RUN with a cleared scoreboard.
- The stall decision is purely combinational from the current cnt and ID fields; no added latency.
- Default parameters, dependent instruction directly behind its producer: stalls 2 cycles, matching no-forwarding behaviour.
- Forwarding configuration (LAT_ALU = 0, LAT_LOAD = 1): ALU dependencies never stall; load-use stalls exactly 1 cycle.
- Cycles with adv = 0 freeze the counters, so stall length is measured in advancing cycles.
- Same register as both rs and rt: one stall condition, with no double counting.
- Simultaneous issue and decrement on the same register: the issue rule (max) applies.
- DRAIN-to-HALTED takes at least 1 cycle after the last counter reaches 0.

## Structure
- dp_types_pkg gains:
  - typedef enum logic [1:0] {RUN, DRAIN, HALTED} hu_state_t;
  - default latency constants LAT_ALU_NOFWD = 2, LAT_LOAD_NOFWD = 2, LAT_ALU_FWD = 0, LAT_LOAD_FWD = 1.
- Interface hazard_ctrl_if carries the ports above, with modports hc and tb.
- Sub-module hazard_scoreboard holds the counter array. It has issue, decrement and read ports (two read indices, one write index) and is parameterised by NREGS and CW.
- The top level contains the FSM, output muxing and the stall counter.

## Test plan
- Defaults. Issue add $3, then present $3 as rs on the next cycle with adv = 1 every cycle -> stall = 1 for 2 cycles, then issues; stall_cnt = 2.
- LAT_ALU = 0, LAT_LOAD = 1. lw $5 then addu using $5 -> exactly 1 stall cycle. ALU-to-ALU dependency -> 0 stall cycles.
- Hold ihit = dhit = 0 for 3 cycles during a stall -> counters frozen; the stall lasts 3 + 2 cycles.
- mispredict asserted while raw = 1 -> if_id/id_ex/ex_mem flushes = 1, pcen = ihit, stall = 0. The scoreboard is unchanged on the next cycle.
- halt with cnt[7] = 2 -> DRAIN for at least 2 advancing cycles with pcen = 0, then HALTED with halted = 1 and all enables 0. A nRST pulse returns to RUN with stall_cnt = 0.
- Force 2^SCW - 1 stall cycles (SCW = 4 build) -> stall_cnt holds at 15.
